// File: rtl/rr_grant_ctrl4_if.sv
// Handshake bundle between four requesters and the rr_grant_ctrl4 arbiter.
// Ports: en/req flow from requesters (master) to arbiter (slave);
//        gnt/gnt_idx/gnt_vld flow back from arbiter to requesters.
interface rr_grant_ctrl4_if;
  logic       en;       // arbiter enable; low drops any grant
  logic [3:0] req;      // level request per requester, held until served
  logic [3:0] gnt;      // one-hot grant, all-zero when idle
  logic [1:0] gnt_idx;  // binary owner index, meaningful when gnt_vld=1
  logic       gnt_vld;  // a grant is active

  modport master (output en, req, input gnt, gnt_idx, gnt_vld);
  modport slave  (input en, req, output gnt, gnt_idx, gnt_vld);
endinterface

// File: rtl/rr_grant_ctrl4.sv
// Purpose : round-robin owner of a shared 4-way resource; registered one-hot grant.
// Latency : grant appears 1 cycle after req is sampled; owner switches on one edge.
// Backpr. : owner holds until it drops req (or, with HOLD_LIMIT_EN, until MAX_HOLD
//           consecutive cycles elapse while others wait); losers keep req asserted.
// Ports   : clk, rst (sync, active-high); arb (rr_grant_ctrl4_if.slave): en, req in;
//           gnt, gnt_idx, gnt_vld out, all registered.
// Config  : define HOLD_LIMIT_EN to enable forced rotation after MAX_HOLD cycles.
module rr_grant_ctrl4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  rr_grant_ctrl4_if.slave  arb
);

  // Counter must be able to represent MAX_HOLD.
  if (2**CNT_W <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_grant_ctrl4: CNT_W too small for MAX_HOLD");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] cand;
  logic [1:0] pick;
  logic       new_grant;
`ifdef HOLD_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // First set bit of r searching p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] res;
    logic [1:0] pos;
    res = p;
    for (int k = 3; k >= 0; k--) begin
      pos = p + 2'(k);
      if (r[pos]) res = pos;
    end
    return res;
  endfunction

  // While granted, the current owner is never a candidate: either it has dropped
  // req (mask is a no-op) or it is being preempted by the hold limit.
  always_comb begin
    cand = arb.req;
    if (state_q == GRANT) cand = arb.req & ~gnt_q;
  end

  assign pick = rr_pick(cand, ptr_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    new_grant = 1'b0;
`ifdef HOLD_LIMIT_EN
    cnt_d     = cnt_q;
`endif

    if (!arb.en) begin
      // Everything back to reset values except the rotation pointer.
      state_d = IDLE;
      idx_d   = 2'd0;
      vld_d   = 1'b0;
`ifdef HOLD_LIMIT_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|cand) new_grant = 1'b1;
        end
        GRANT: begin
          if (arb.req[idx_q]) begin
`ifdef HOLD_LIMIT_EN
            if ((cnt_q >= CNT_W'(MAX_HOLD)) && (|cand)) begin
              new_grant = 1'b1;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
`endif
          end else if (|cand) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = 2'd0;
            vld_d   = 1'b0;
`ifdef HOLD_LIMIT_EN
            cnt_d   = '0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase

      if (new_grant) begin
        state_d = GRANT;
        idx_d   = pick;
        vld_d   = 1'b1;
        ptr_d   = pick + 2'd1;
`ifdef HOLD_LIMIT_EN
        cnt_d   = CNT_W'(1);
`endif
      end
    end

    // 2-to-4 decode of the next owner index, enabled by next valid.
    gnt_d = vld_d ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
      gnt_q   <= 4'b0000;
`ifdef HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
`ifdef HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign arb.gnt     = gnt_q;
  assign arb.gnt_idx = idx_q;
  assign arb.gnt_vld = vld_q;

endmodule

// File: tb/tb_rr_grant_ctrl4.sv
// Directed and randomized checks of the rr_grant_ctrl4 round-robin arbiter.
module tb_rr_grant_ctrl4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rr_grant_ctrl4_if arb();

  rr_grant_ctrl4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    arb.en  = 1'b1;
    arb.req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] req, input logic [3:0] exp_gnt);
    arb.req = req;
    tick();
    check(tag, 32'(arb.gnt), 32'(exp_gnt));
  endtask

  logic [3:0] seq_req [4];
  logic [3:0] seq_gnt [4];
  logic [3:0] p_req, p_gnt;
  logic       p_en;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst     = 1'b1;
    arb.en  = 1'b0;
    arb.req = 4'b0000;

    // Reset state, even with en/req active.
    arb.en  = 1'b1;
    arb.req = 4'b1111;
    tick();
    check("rst_gnt", 32'(arb.gnt), 32'h0);
    check("rst_vld", 32'(arb.gnt_vld), 32'h0);
    check("rst_idx", 32'(arb.gnt_idx), 32'h0);

    // 1: all request, each owner drops in turn -> 0,1,2,3.
    do_reset();
    seq_req = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
    seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      step_chk($sformatf("t1_gnt%0d", i), seq_req[i], seq_gnt[i]);
      check($sformatf("t1_idx%0d", i), 32'(arb.gnt_idx), i);
      check($sformatf("t1_vld%0d", i), 32'(arb.gnt_vld), 32'h1);
    end
    step_chk("t1_idle", 4'b0000, 4'b0000);
    check("t1_idle_vld", 32'(arb.gnt_vld), 32'h0);

    // 2: serve 2 (ptr=3), then 0101 wraps to 0; then 0 drops -> 2.
    do_reset();
    step_chk("t2_own2", 4'b0100, 4'b0100);
    step_chk("t2_idle", 4'b0000, 4'b0000);
    step_chk("t2_wrap", 4'b0101, 4'b0001);
    step_chk("t2_sw2", 4'b0100, 4'b0100);
    check("t2_idx", 32'(arb.gnt_idx), 32'h2);

    // 3: en low drops the grant, en high regrants after 1 cycle.
    do_reset();
    step_chk("t3_own1", 4'b0010, 4'b0010);
    arb.en = 1'b0;
    tick();
    check("t3_en0_gnt", 32'(arb.gnt), 32'h0);
    check("t3_en0_vld", 32'(arb.gnt_vld), 32'h0);
    tick();
    check("t3_en0_gnt2", 32'(arb.gnt), 32'h0);
    arb.en = 1'b1;
    tick();
    check("t3_en1_gnt", 32'(arb.gnt), 32'h2);
    check("t3_en1_idx", 32'(arb.gnt_idx), 32'h1);

    // 4: rst while owner 3 still requests; afterwards ptr back at 0.
    do_reset();
    step_chk("t4_own3", 4'b1000, 4'b1000);
    rst = 1'b1;
    tick();
    check("t4_rst_gnt", 32'(arb.gnt), 32'h0);
    rst = 1'b0;
    step_chk("t4_after", 4'b1001, 4'b0001);
    // ptr reset check: with stale ptr=2, 0110 would pick 2.
    do_reset();
    step_chk("t4b_own1", 4'b0010, 4'b0010);
    rst = 1'b1;
    arb.req = 4'b0000;
    tick();
    rst = 1'b0;
    step_chk("t4b_ptr0", 4'b0110, 4'b0010);

`ifdef HOLD_LIMIT_EN
    // 5: forced rotation after 8 cycles.
    do_reset();
    arb.req = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t5_o0_%0d", i), 32'(arb.gnt), 32'h1);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t5_o1_%0d", i), 32'(arb.gnt), 32'h2);
    end
    tick();
    check("t5_back0", 32'(arb.gnt), 32'h1);
    do_reset();
    arb.req = 4'b0001;
    for (int i = 0; i < 24; i++) begin
      tick();
      check($sformatf("t5_solo%0d", i), 32'(arb.gnt), 32'h1);
    end
`else
    // Without hold limit, owner keeps the grant indefinitely.
    do_reset();
    arb.req = 4'b0011;
    for (int i = 0; i < 24; i++) begin
      tick();
      check($sformatf("t5_hold%0d", i), 32'(arb.gnt), 32'h1);
    end
`endif

    // 6: random req/en, property checks against previous-cycle inputs.
    do_reset();
    p_req = 4'b0000;
    p_en  = 1'b1;
    p_gnt = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      arb.en  = ($urandom_range(0, 15) != 0);
      arb.req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : p_req;
      p_req = arb.req;
      p_en  = arb.en;
      tick();
      check("r_onehot", 32'($countones(arb.gnt) <= 1), 32'h1);
      check("r_vld", 32'(arb.gnt_vld), 32'(|arb.gnt));
      if (arb.gnt_vld) begin
        check("r_idx", 32'(arb.gnt[arb.gnt_idx]), 32'h1);
        check("r_had_req", 32'(|(arb.gnt & p_req)), 32'h1);
        check("r_had_en", 32'(p_en), 32'h1);
      end
`ifndef HOLD_LIMIT_EN
      if (p_en && (|(p_gnt & p_req))) begin
        check("r_held", 32'(arb.gnt), 32'(p_gnt));
      end
`endif
      p_gnt = arb.gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
